// File: rtl/divu_seq.sv
// Iterative restoring divider: signed/unsigned, full/word mode, with remainder.
// Define DIVU_SEQ_EARLY_OUT_EN to skip CALC when |dividend| < |divisor|.
module divu_seq #(
   parameter int WIDTH  = 64,
   parameter int WORD_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             is_signed,
   input  logic             is_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] rem,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] WMASK =
      {{(WIDTH-WORD_W){1'b0}}, {WORD_W{1'b1}}};
   localparam logic [WIDTH-1:0] WMIN =
      {{(WIDTH-WORD_W){1'b0}}, 1'b1, {(WORD_W-1){1'b0}}};
   localparam logic [WIDTH-1:0] FMIN =
      {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIXUP,
      DONE
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [CW-1:0]    cnt_q;
   logic             word_q;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH-1:0] nmask;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] maga;
   logic [WIDTH-1:0] magb;
   logic             sa;
   logic             sb;
   logic             b_zero;
   logic             ovf;
   logic             early;
   logic             accept;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH-1:0] r_sub;
   logic             r_ge;
   logic [CW-1:0]    cnt_last;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   function automatic logic [WIDTH-1:0] sext(
      input logic [WIDTH-1:0] x,
      input logic             w
   );
      if (w)
         return {{(WIDTH-WORD_W){x[WORD_W-1]}}, x[WORD_W-1:0]};
      return x;
   endfunction

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_ready & in_valid & ~flush;

   // Operand selection, magnitudes and special-case detection at accept
   always_comb begin
      nmask  = is_word ? WMASK : '1;
      opa    = srca & nmask;
      opb    = srcb & nmask;
      sa     = is_signed & (is_word ? srca[WORD_W-1] : srca[WIDTH-1]);
      sb     = is_signed & (is_word ? srcb[WORD_W-1] : srcb[WIDTH-1]);
      maga   = (sa ? -opa : opa) & nmask;
      magb   = (sb ? -opb : opb) & nmask;
      b_zero = (opb == '0);
      ovf    = is_signed
             & (opa == (is_word ? WMIN : FMIN))
             & (opb == nmask);
      early  = 1'b0;
`ifdef DIVU_SEQ_EARLY_OUT_EN
      early  = ~sa & ~b_zero & (maga < magb);
`endif
   end

   // Restoring step: N+1-bit compare keeps the shifted remainder exact
   always_comb begin
      r_sh     = {r_q, a_q[WIDTH-1]};
      r_ge     = (r_sh >= {1'b0, b_q});
      r_sub    = r_sh[WIDTH-1:0] - b_q;
      cnt_last = word_q ? CW'(WORD_W - 1) : CW'(WIDTH - 1);
      q_fix    = sign_q ? -q_q : q_q;
      r_fix    = sign_r ? -r_q : r_q;
   end

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  if (b_zero | ovf)
                     state_n = DONE;
                  else if (early)
                     state_n = FIXUP;
                  else
                     state_n = CALC;
               end
            end
            CALC: begin
               if (cnt_q == cnt_last)
                  state_n = FIXUP;
            end
            FIXUP: state_n = DONE;
            DONE: begin
               if (out_ready)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         word_q   <= 1'b0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         quotient <= '0;
         rem      <= '0;
      end else begin
         if (accept) begin
            word_q <= is_word;
            sign_q <= sa ^ sb;
            sign_r <= sa;
            b_q    <= magb;
            q_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            // Word dividend is left-aligned so CALC always takes the MSB
            a_q    <= is_word ? (maga << (WIDTH - WORD_W)) : maga;
            if (b_zero) begin
               quotient <= sext(nmask, is_word);
               rem      <= sext(opa, is_word);
            end else if (ovf) begin
               quotient <= sext(opa, is_word);
               rem      <= '0;
            end else if (early) begin
               r_q      <= maga;
            end
         end
         if (state == CALC) begin
            a_q   <= a_q << 1;
            q_q   <= {q_q[WIDTH-2:0], r_ge};
            r_q   <= r_ge ? r_sub : r_sh[WIDTH-1:0];
            cnt_q <= cnt_q + CW'(1);
         end
         if (state == FIXUP && !flush) begin
            quotient <= sext(q_fix, word_q);
            rem      <= sext(r_fix, word_q);
         end
      end
   end

endmodule

// File: doc/divu_seq.md
Name: divu_seq

Overview:
- Parametrised iterative integer divider for the execute stage; successor to the single-mode 64-bit unsigned divider.
- Supports signed and unsigned division, full-width and word (32-bit, sign-extended) modes, and remainder output.
- Uses a valid/ready handshake on both input and output, plus a flush input for pipeline squash.
- Produces one quotient bit per cycle using the restoring algorithm on operand magnitudes, followed by a sign fix-up cycle.

Parameters:
- WIDTH, 64, full operand/result width in bits; must be even and ≥ 8.
- WORD_W, 32, operand width in word mode; must satisfy WORD_W < WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- flush  input  1  abort any in-flight operation; back to IDLE next edge
- in_valid  input  1  operands/op valid
- in_ready  output  1  divider can accept (high only in IDLE)
- srca  input  WIDTH  dividend
- srcb  input  WIDTH  divisor
- is_signed  input  1  1 = signed (div/rem), 0 = unsigned
- is_word  input  1  1 = operate on low WORD_W bits, sign-extend results to WIDTH
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  quotient
- rem  output  WIDTH  remainder
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-high, highest priority. State goes to IDLE. Outputs: quotient=0, rem=0, out_valid=0, busy=0, in_ready=1.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs at an edge with in_valid=1 and flush=0.
  - On accept, latch the op, compute N (= WORD_W if is_word, else WIDTH), and select operands (low N bits if is_word).
  - If signed, store magnitudes and latch sign_q = sa^sb and sign_r = sa.
  - Special cases are decided at accept, bypass CALC, and go straight to DONE:
    - Divisor == 0: quotient = all ones (N bits), rem = dividend (N bits).
    - Signed, dividend == most-negative, divisor == −1: quotient = dividend, rem = 0.
  - Otherwise: clear the partial remainder and counter; go to CALC.
- CALC:
  - One step per edge: R = {R[N-2:0], A[N-1-i]}; Q <<= 1; if R ≥ |B| then R −= |B| and set Q[0].
  - The counter increments each step. After the N-th step, go to FIXUP.
  - Comparison and subtraction are N+1 bits wide to avoid overflow.
- FIXUP (one cycle):
  - If signed: negate Q when sign_q=1; negate R when sign_r=1.
  - If is_word: sign-extend bit WORD_W−1 of both results to WIDTH.
  - Go to DONE.
- DONE:
  - out_valid=1; quotient and rem are stable.
  - Hold until out_valid && out_ready; then go to IDLE with out_valid=0 on the next edge.
  - Results are not cleared on handshake; they remain visible until the next result is produced.
- Latency (accept edge to first cycle out_valid=1):
  - Normal: N+2 cycles (66 for full width, 34 for word mode at defaults).
  - Special case: 1 cycle.
- Throughput: one op in flight. in_ready is low from the accept edge through the output-handshake edge. A new op is accepted no earlier than the cycle after the output handshake.
- flush:
  - Any state → IDLE on the next edge; out_valid drops; no result is delivered.
  - flush in the same cycle as in_valid in IDLE: the op is not accepted.
  - flush has priority over out_ready.
- Inputs srca, srcb, is_signed, is_word are sampled only at the accept edge; later changes have no effect.

Optional Feature:
- Macro: DIVU_SEQ_EARLY_OUT_EN.
- Defined:
  - At accept, an unsigned (or non-negative signed) dividend with magnitude < divisor magnitude (divisor ≠ 0) bypasses CALC and goes to FIXUP with Q=0, R=dividend magnitude.
  - Latency for these ops is 2 cycles.
- Undefined: such ops take the normal N+2 cycle path with identical results.

Test Plan:
- Unsigned full width: srca=100, srcb=7 → quotient=14, rem=2, out_valid 66 cycles after accept.
- Signed full width: srca=−7, srcb=2 → quotient=−3 (0xFFFF_FFFF_FFFF_FFFD), rem=−1 (all ones).
- Special cases:
  - srcb=0, srca=0x1234 (signed and unsigned) → quotient=all ones, rem=0x1234, latency 1.
  - Signed, srca=0x8000_0000_0000_0000, srcb=−1 → quotient=0x8000_0000_0000_0000, rem=0.
- Word signed: srca=0x0000_0001_8000_0000, srcb=1 → quotient=0xFFFF_FFFF_8000_0000, rem=0, latency 34.
- Handshake and flush:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid and results stable; in_ready=0 throughout.
  - Assert flush mid-CALC → IDLE next cycle; a new op is accepted and completes correctly.
- Reset mid-CALC → next cycle out_valid=0, quotient=0, rem=0, in_ready=1.
- If DIVU_SEQ_EARLY_OUT_EN: srca=3, srcb=10 → quotient=0, rem=3, latency 2.
